// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage registers: FSM encoding,
// per-boundary payload/control widths and control-bundle bit positions.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

  // IF/ID carries PC+instruction only, so its control bundle is a single spare bit.
  localparam int IFID_DATA_W  = 64;
  localparam int IFID_CTRL_W  = 1;
  localparam int IDEX_DATA_W  = 96;
  localparam int IDEX_CTRL_W  = 10;
  localparam int EXMEM_DATA_W = 72;
  localparam int EXMEM_CTRL_W = 5;
  localparam int MEMWB_DATA_W = 69;
  localparam int MEMWB_CTRL_W = 2;

  localparam int REGDST   = 0;
  localparam int JUMP     = 1;
  localparam int BRANCH   = 2;
  localparam int MEMREAD  = 3;
  localparam int MEMTOREG = 4;
  localparam int MEMWRITE = 5;
  localparam int ALUSRC   = 6;
  localparam int ALUOP_LO = 7;
  localparam int ALUOP_HI = 8;
  localparam int REGWRITE = 9;

endpackage

// File: rtl/pipe_stage_elastic_if.sv
// Handshake bundle around one elastic stage register: upstream side, downstream
// side and flush. The stage itself uses the slave modport.
interface pipe_stage_elastic_if #(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 10
) ();

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic              flush;

  modport master (
    output in_valid, in_data, in_ctrl, out_ready, flush,
    input  in_ready, out_valid, out_data, out_ctrl
  );

  modport slave (
    input  in_valid, in_data, in_ctrl, out_ready, flush,
    output in_ready, out_valid, out_data, out_ctrl
  );

endinterface

// File: rtl/pipe_stage_elastic_slot.sv
// pipe_slot: one payload+control register with load enable and valid bit.
// Clear wins over load and drops only the valid bit; the payload is kept.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ld,
  input  logic              clr,
  input  logic [DATA_W-1:0] d_data,
  input  logic [CTRL_W-1:0] d_ctrl,
  output logic              q_vld,
  output logic [DATA_W-1:0] q_data,
  output logic [CTRL_W-1:0] q_ctrl
);

  logic              vld_q, vld_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    ctrl_d = ctrl_q;
    if (clr) begin
      vld_d = 1'b0;
    end else if (ld) begin
      vld_d  = 1'b1;
      data_d = d_data;
      ctrl_d = d_ctrl;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      ctrl_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
      ctrl_q <= ctrl_d;
    end
  end

  assign q_vld  = vld_q;
  assign q_data = data_q;
  assign q_ctrl = ctrl_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic inter-stage register with a 2-entry skid buffer and registered in_ready.
// Define PIPE_STAGE_PERF_EN to add saturating stall/bubble/flush counters.
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 10
) (
  input  logic                      clk,
  input  logic                      reset_n,
  pipe_stage_elastic_if.slave       bus
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]               stall_cnt,
  output logic [31:0]               bubble_cnt,
  output logic [15:0]               flush_cnt
`endif
);

  state_e            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              in_fire, out_fire;
  logic              main_ld, main_clr, skid_ld, skid_clr;
  logic              main_vld, skid_vld;
  logic [DATA_W-1:0] main_data, skid_data, main_src_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_src_ctrl;

  assign in_fire  = bus.in_valid & in_ready_q;
  assign out_fire = main_vld & bus.out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (in_fire) state_d = ST_FULL;
        ST_FULL: begin
          if (in_fire && !out_fire)      state_d = ST_SKID;
          else if (!in_fire && out_fire) state_d = ST_EMPTY;
        end
        ST_SKID:  if (out_fire) state_d = ST_FULL;
        default:  state_d = ST_EMPTY;
      endcase
    end
    // Ready only depends on where we are going, never on this cycle's out_ready path.
    in_ready_d = (state_d != ST_SKID);
  end

  always_comb begin
    main_ld  = 1'b0;
    skid_ld  = 1'b0;
    main_clr = bus.flush;
    skid_clr = bus.flush;
    if (!bus.flush) begin
      case (state_q)
        ST_EMPTY: main_ld = in_fire;
        ST_FULL: begin
          main_ld  = in_fire & out_fire;
          skid_ld  = in_fire & ~out_fire;
          main_clr = ~in_fire & out_fire;
        end
        ST_SKID: begin
          main_ld  = out_fire;
          skid_clr = out_fire;
        end
        default: ;
      endcase
    end
  end

  // A held skid entry always refills main before any newer input can.
  assign main_src_data = skid_vld ? skid_data : bus.in_data;
  assign main_src_ctrl = skid_vld ? skid_ctrl : bus.in_ctrl;

  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
    .clk     (clk),
    .reset_n (reset_n),
    .ld      (main_ld),
    .clr     (main_clr),
    .d_data  (main_src_data),
    .d_ctrl  (main_src_ctrl),
    .q_vld   (main_vld),
    .q_data  (main_data),
    .q_ctrl  (main_ctrl)
  );

  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
    .clk     (clk),
    .reset_n (reset_n),
    .ld      (skid_ld),
    .clr     (skid_clr),
    .d_data  (bus.in_data),
    .d_ctrl  (bus.in_ctrl),
    .q_vld   (skid_vld),
    .q_data  (skid_data),
    .q_ctrl  (skid_ctrl)
  );

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = main_vld;
  assign bus.out_data  = main_data;
  assign bus.out_ctrl  = main_vld ? main_ctrl : '0;

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (main_vld && !bus.out_ready) stall_cnt_d  = sat_inc32(stall_cnt_q);
    if (!main_vld)                  bubble_cnt_d = sat_inc32(bubble_cnt_q);
    if (bus.flush)                  flush_cnt_d  = sat_inc16(flush_cnt_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
  assign flush_cnt  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Scoreboard bench for pipe_stage_elastic: accepted entries queue up in a FIFO model,
// a negedge monitor compares every presented output against the queue head.
module tb_pipe_stage_elastic;
  import pipe_pkg::*;

  localparam int DATA_W = 96;
  localparam int CTRL_W = 10;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;
  } item_t;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  pipe_stage_elastic_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) bus ();

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_cnt, bubble_cnt;
  logic [15:0] flush_cnt;
`endif

  pipe_stage_elastic #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt),
    .flush_cnt  (flush_cnt)
`endif
  );

  item_t exp_q[$];
  int    n_vec = 0;
  int    n_err = 0;
  logic  mon_en = 1'b0;
  logic  rdy_exp = 1'b0;

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: the head of the model FIFO is what the stage must be presenting.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("out_valid", DATA_W'(bus.out_valid), DATA_W'(exp_q.size() > 0));
      if (exp_q.size() > 0) begin
        chk("out_data", bus.out_data, exp_q[0].data);
        chk("out_ctrl", DATA_W'(bus.out_ctrl), DATA_W'(exp_q[0].ctrl));
        if (bus.out_ready) void'(exp_q.pop_front());
      end else begin
        chk("bubble_ctrl", DATA_W'(bus.out_ctrl), '0);
      end
    end
  end

  // One cycle of stimulus; acceptance follows the model's own ready (FIFO depth 2).
  task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                       input logic ordy, input logic fl);
    @(posedge clk); #1;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_ctrl   = c;
    bus.out_ready = ordy;
    bus.flush     = fl;
    @(negedge clk); #1;
    chk("in_ready", DATA_W'(bus.in_ready), DATA_W'(rdy_exp));
    if (fl) exp_q.delete();
    else if (v && rdy_exp) exp_q.push_back('{data: d, ctrl: c});
    rdy_exp = (exp_q.size() < 2);
  endtask

  task automatic do_reset();
    mon_en        = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_ctrl   = 10'h3FF;
    bus.in_data   = {$urandom, $urandom, $urandom};
    bus.out_ready = 1'b1;
    bus.flush     = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("rst_out_valid", DATA_W'(bus.out_valid), '0);
    chk("rst_out_ctrl", DATA_W'(bus.out_ctrl), '0);
    chk("rst_out_data", bus.out_data, '0);
    chk("rst_in_ready", DATA_W'(bus.in_ready), '0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_hold_valid", DATA_W'(bus.out_valid), '0);
    chk("rst_hold_in_ready", DATA_W'(bus.in_ready), '0);
    reset_n = 1'b1;
    #1;
    chk("rel_in_ready_pre", DATA_W'(bus.in_ready), '0);
    @(posedge clk); #1;
    chk("rel_in_ready_post", DATA_W'(bus.in_ready), DATA_W'(1));
    bus.in_valid = 1'b0;
    rdy_exp      = 1'b1;
    mon_en       = 1'b1;
  endtask

  function automatic logic [DATA_W-1:0] rdata();
    return {$urandom, $urandom, $urandom};
  endfunction

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_ctrl   = '0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
    do_reset();

    // Streaming 1..8 back-to-back with the consumer always ready
    for (int i = 1; i <= 8; i++) drive(1'b1, DATA_W'(i), CTRL_W'($urandom), 1'b1, 1'b0);
    repeat (2) drive(1'b0, '0, '0, 1'b1, 1'b0);

    // Backpressure: B arrives while A stalls -> skid, then both drain in order
    drive(1'b1, 96'hA, 10'h0AA, 1'b1, 1'b0);
    drive(1'b1, 96'hB, 10'h0BB, 1'b0, 1'b0);
    repeat (2) drive(1'b1, 96'hEE, 10'h0EE, 1'b0, 1'b0);
    repeat (3) drive(1'b0, '0, '0, 1'b1, 1'b0);

    // Flush while two entries are held, with a new entry C offered
    drive(1'b1, 96'hA1, 10'h111, 1'b0, 1'b0);
    drive(1'b1, 96'hB1, 10'h122, 1'b0, 1'b0);
    drive(1'b1, 96'hC1, 10'h133, 1'b0, 1'b1);
    repeat (3) drive(1'b0, '0, '0, 1'b1, 1'b0);

    // Bubble masking after a consumed entry
    drive(1'b1, 96'hD, 10'h2A5, 1'b1, 1'b0);
    repeat (4) drive(1'b0, rdata(), '0, 1'b1, 1'b0);

    // Random traffic with stalls and occasional flushes
    for (int i = 0; i < 1500; i++)
      drive(($urandom_range(0, 9) < 7), rdata(), CTRL_W'($urandom),
            ($urandom_range(0, 9) < 6), ($urandom_range(0, 39) == 0));

    // Reset while entries are in flight
    repeat (6) drive(1'b1, rdata(), CTRL_W'($urandom), 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 300; i++)
      drive(($urandom_range(0, 1) == 1), rdata(), CTRL_W'($urandom),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 49) == 0));
    repeat (4) drive(1'b0, '0, '0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
Parametrised successor to the fixed ID/EX-style stage register: a generic inter-stage register for IF/ID, ID/EX, EX/MEM and MEM/WB.
Carries a DATA_W payload and a CTRL_W control bundle.
Adds a valid/ready handshake with a 2-entry skid buffer, so in_ready is registered and throughput stays at 1 transfer/cycle.
Flush inserts bubbles whose control bits are guaranteed zero. Instantiated between each pair of pipeline stages.

Parameters:
DATA_W, 96, payload width (operands, immediate, register addresses)
CTRL_W, 10, control bundle width; forced to zero on bubbles

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  upstream has an entry
in_ready  out  1  stage can accept; registered
in_data  in  DATA_W  upstream payload
in_ctrl  in  CTRL_W  upstream control bundle
out_valid  out  1  downstream entry present
out_ready  in  1  downstream accepts (0 = stall)
out_data  out  DATA_W  payload to next stage
out_ctrl  out  CTRL_W  control to next stage; 0 when out_valid=0
flush  in  1  synchronous kill of all held and incoming entries

Behaviour:
- Handshake and storage:
  - in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
  - Storage is a main slot (drives outputs) and a skid slot.
- States (2-bit):
  - EMPTY: in_ready=1, out_valid=0.
  - FULL: in_ready=1, out_valid=1.
  - SKID: in_ready=0, out_valid=1.
- Transitions, evaluated each rising edge, flush has priority:
  - flush=1 -> EMPTY from any state; both slots invalidated; any in_fire that cycle is dropped (upstream treats it as consumed).
  - EMPTY & in_fire -> FULL; main<=in.
  - FULL & in_fire & out_fire -> FULL; main<=in.
  - FULL & in_fire & !out_fire -> SKID; skid<=in; main unchanged.
  - FULL & !in_fire & out_fire -> EMPTY.
  - SKID & out_fire -> FULL; main<=skid.
  - SKID & !out_fire -> SKID; hold.
  - All other cases hold.
- Latency and throughput:
  - Latency is 1 cycle: data accepted at edge N appears on out_* after edge N.
  - Sustained 1 transfer/cycle while out_ready=1.
- Data ordering: FIFO order is preserved; the skid entry never overtakes main.
- Registered ready: in_ready is a flop, set to (next_state != SKID); no combinational path from out_ready to in_ready.
- Bubble masking:
  - out_ctrl = main_ctrl when out_valid, else all-zero.
  - out_data holds its last value when invalid (don't-care to consumers).
- Reset (reset_n=0, asynchronous):
  - state=EMPTY; in_ready=0; out_valid=0; out_ctrl=0; out_data=0; skid slot cleared.
  - in_ready rises at the first clk edge after reset_n deasserts.
- Flush and reset timing:
  - flush during SKID discards both entries; in_ready returns to 1 the next cycle.
  - Reset mid-transfer discards everything with no partial update.
- Width rules: no arithmetic on payload; widths pass through unchanged.

Optional Feature:
Macro PIPE_STAGE_PERF_EN.
- Defined: adds outputs stall_cnt[31:0] (cycles with out_valid & !out_ready), bubble_cnt[31:0] (cycles with out_valid=0) and flush_cnt[15:0] (flush pulses).
  - All counters saturate at max, not wrap.
  - All reset to 0 on reset_n=0.
- Undefined: ports and logic absent; core behaviour identical.

Decomposition:
- Shared package pipe_pkg holds:
  - state encoding (ST_EMPTY=2'd0, ST_FULL=2'd1, ST_SKID=2'd2);
  - per-stage width constants (IFID_DATA_W, IDEX_DATA_W, IDEX_CTRL_W=10, EXMEM_*, MEMWB_*);
  - control-bundle bit-index constants (REGDST, JUMP, BRANCH, MEMREAD, MEMTOREG, MEMWRITE, ALUSRC, ALUOP[1:0], REGWRITE).
- One natural sub-module: pipe_slot, a DATA_W+CTRL_W register with load enable and valid bit, instantiated twice (main, skid).
- Perf counters stay inline under the macro.

Test Plan:
- Reset: hold reset_n=0 with in_valid=1, in_ctrl=10'h3FF -> out_valid=0, out_ctrl=0, in_ready=0; release -> in_ready=1 after the first edge.
- Streaming: out_ready=1, 8 back-to-back entries data=1..8 -> out_data 1..8 on consecutive cycles, 1-cycle latency, in_ready stays 1.
- Backpressure: send A then B; drop out_ready at the edge B arrives -> state SKID, in_ready=0, out_data=A held; raise out_ready -> A then B delivered in order, no loss or duplicate.
- Flush in SKID: entries A,B held, flush=1 with in_valid=1 data=C -> next cycle out_valid=0, out_ctrl=0, C never emitted, in_ready=1.
- Bubble masking: in_valid=0 for 3 cycles after entry with ctrl=10'h2A5 is consumed -> out_ctrl=0 on all 3 cycles.
- PIPE_STAGE_PERF_EN: 5 stall cycles, 3 empty cycles, 2 flush pulses -> stall_cnt=5, bubble_cnt=3, flush_cnt=2; forced stall of 2^32+4 cycles -> stall_cnt=32'hFFFFFFFF.
